pixel_stream_controller: RTL and testbench
==========================================

PIXEL_STREAM_CONTROLLER -- requirements
Module: pixel_stream_controller

Interface
REQ-001 SHALL have parameter NumPixels, default 76800, meaning pixels per frame (320x240).
REQ-002 SHALL have parameter NumColourBits, default 12, meaning pixel width (4 bits each R, G, B).
REQ-003 SHALL have parameter AddrWidth, default 17, meaning the per-buffer pixel address width.
REQ-004 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port enable  in  1  level; high requests continuous frame streaming.
REQ-007 Port buf_select  in  1  requested frame buffer (0/1) for the next frame.
REQ-008 Port rd_en  out  1  frame-buffer BRAM read strobe.
REQ-009 Port rd_addr  out  AddrWidth+1  read address: {buffer bit, pixel index}.
REQ-010 Port rd_data  in  NumColourBits  BRAM read data, valid exactly 1 cycle after rd_en.
REQ-011 Port pixel  out  NumColourBits  Avalon-ST pixel to the 30-bit colour expander.
REQ-012 Port valid / ready  out / in  1 each  Avalon-ST handshake; transfer = valid & ready.
REQ-013 Port startofpacket / endofpacket  out  1 each  pixel index 0 / NumPixels-1 markers, qualified by valid.
REQ-014 Port active_buf  out  1  buffer of the frame currently being read.
REQ-015 Port frame_done  out  1  one-cycle pulse on the transfer of the endofpacket pixel.

Function
REQ-016 States SHALL be IDLE, STREAM, FINISH.
REQ-017 IDLE -> STREAM SHALL occur when enable=1 at a rising edge; buf_select SHALL be latched into active_buf and the read index SHALL be cleared to 0 on that edge.
REQ-018 In STREAM, the block SHALL issue reads in index order 0..NumPixels-1 and hold a 2-entry output FIFO of {pixel, sop, eop}.
REQ-019 Credit rule: rd_en SHALL be 1 only when (entries + reads_in_flight - pop_this_cycle) < 2, where pop = valid & ready; the FIFO SHALL never overflow and no read data SHALL be lost.
REQ-020 Read data SHALL be pushed into the FIFO on the edge after its rd_en; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-021 valid SHALL equal FIFO non-empty; pixel, startofpacket and endofpacket SHALL come from the FIFO head and stay stable while valid=1 and ready=0.
REQ-022 Latency: the first valid SHALL appear 2 cycles after the edge that enters STREAM (rd_en in cycle +1, valid in cycle +2) when ready is high.
REQ-023 With ready held high, throughput SHALL be one pixel per cycle after the initial latency.
REQ-024 After issuing the read for index NumPixels-1, the read index SHALL wrap to 0, and buf_select SHALL be re-latched into the buffer bit of rd_addr for the following frame.
REQ-025 A buffer swap SHALL take effect only at a frame boundary; active_buf SHALL update on the transfer of the endofpacket pixel, never mid-frame.
REQ-026 If enable=0 when the read for index NumPixels-1 is issued, the block SHALL stop issuing reads and enter FINISH.
REQ-027 FINISH SHALL drain the FIFO and return to IDLE on the edge after the endofpacket transfer.
REQ-028 enable falling mid-frame SHALL NOT truncate the frame; a full frame SHALL always be delivered.
REQ-029 In IDLE, rd_en and valid SHALL be 0.
REQ-030 buf_select changes while in IDLE SHALL have no effect until the next start.

Reset
REQ-031 reset=0 SHALL asynchronously force: state IDLE, FIFO empty, in-flight count 0, read index 0, rd_en 0, rd_addr 0, valid 0, startofpacket 0, endofpacket 0, pixel 0, active_buf 0, frame_done 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; read data returning after the release of reset SHALL be discarded.
REQ-033 After reset release, streaming SHALL restart only through IDLE -> STREAM with index 0.

Verification
REQ-034 Scenario 1: reset release, enable=1, ready=1, buf_select=0 -> rd_addr 0,1,2,... from cycle +1; valid from cycle +2; sop on pixel 0; eop and frame_done on pixel 76799; no gap between frames.
REQ-035 Scenario 2: random ready toggling, 30% low -> pixel sequence equals BRAM contents in order; rd_addr never more than 2 ahead of transfers; output stable during stalls.
REQ-036 Scenario 3: buf_select 0->1 at pixel 1000 -> current frame keeps addresses with MSB=0; next frame's addresses have MSB=1; active_buf goes to 1 on the eop transfer.
REQ-037 Scenario 4: enable drops at pixel 500 -> all 76800 pixels delivered; then IDLE with rd_en=0 and valid=0; re-enable restarts at index 0.
REQ-038 Scenario 5: reset pulsed low at pixel 300 with ready=0 -> outputs clear immediately; after release and enable, the first transfer is pixel 0 with sop=1.
REQ-039 Scenario 6: ready=0 for 10 cycles from the start -> exactly 2 reads issued; FIFO full; first transfer is pixel 0 once ready rises.

Source files
------------

// File: rtl/pixel_stream_controller.sv
// Streams frames out of a double-buffered frame BRAM as Avalon-ST packets.
// A 2-entry FIFO with read credits absorbs the 1-cycle BRAM latency and sink stalls.
module pixel_stream_controller #(
  parameter int NumPixels     = 76800,
  parameter int NumColourBits = 12,
  parameter int AddrWidth     = 17
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     enable_i,
  input  logic                     buf_select_i,
  output logic                     rd_en_o,
  output logic [AddrWidth:0]       rd_addr_o,
  input  logic [NumColourBits-1:0] rd_data_i,
  output logic [NumColourBits-1:0] pixel_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     startofpacket_o,
  output logic                     endofpacket_o,
  output logic                     active_buf_o,
  output logic                     frame_done_o
);
  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumPixels - 1);
  localparam int EntryW = NumColourBits + 2;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic                 rd_buf_q, rd_buf_d;
  logic                 active_buf_q, active_buf_d;
  logic                 inflight_q, inflight_sop_q, inflight_eop_q;
  logic [EntryW-1:0]    fifo_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  logic [EntryW-1:0]    head;
  logic                 pop, rd_en;
  logic [2:0]           credit_used;

  // FIFO entry layout: {pixel, sop, eop}
  assign head        = fifo_q[rd_ptr_q];
  assign valid_o     = (count_q != 2'd0);
  assign pop         = valid_o & ready_i;
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_buf_d     = rd_buf_q;
    active_buf_d = active_buf_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d      = STREAM;
          idx_d        = '0;
          rd_buf_d     = buf_select_i;
          active_buf_d = buf_select_i;
        end
      end
      STREAM: begin
        rd_en = (credit_used < 3'd2);
        if (rd_en) begin
          if (idx_q == LastIdx) begin
            idx_d    = '0;
            rd_buf_d = buf_select_i;
            if (!enable_i) state_d = FINISH;
          end else begin
            idx_d = idx_q + AddrWidth'(1);
          end
        end
        // rd_buf_q already holds the next frame's buffer once the last read has wrapped
        if (pop && head[0]) active_buf_d = rd_buf_q;
      end
      FINISH: begin
        if (pop && head[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      rd_buf_q       <= 1'b0;
      active_buf_q   <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rd_buf_q       <= rd_buf_d;
      active_buf_q   <= active_buf_d;
      inflight_q     <= rd_en;
      inflight_sop_q <= rd_en & (idx_q == '0);
      inflight_eop_q <= rd_en & (idx_q == LastIdx);
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= {rd_data_i, inflight_sop_q, inflight_eop_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign rd_en_o         = rd_en;
  assign rd_addr_o       = rd_en ? {rd_buf_q, idx_q} : '0;
  assign pixel_o         = valid_o ? head[EntryW-1:2] : '0;
  assign startofpacket_o = valid_o & head[1];
  assign endofpacket_o   = valid_o & head[0];
  assign active_buf_o    = active_buf_q;
  assign frame_done_o    = pop & head[0];
endmodule

// File: tb/tb_pixel_stream_controller.sv
// Directed bench for pixel_stream_controller with a small frame size; a queue of
// expected {pixel, sop, eop} is filled as reads are issued and drained on transfers.
module tb_pixel_stream_controller;
  localparam int N  = 16;
  localparam int CB = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n, enable, buf_select, ready;
  logic          rd_en, valid, sop, eop, active_buf, frame_done;
  logic [AW:0]   rd_addr;
  logic [CB-1:0] rd_data, pixel;

  always #5 clk = ~clk;

  pixel_stream_controller #(.NumPixels(N), .NumColourBits(CB), .AddrWidth(AW)) dut (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .buf_select_i(buf_select),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .pixel_o(pixel), .valid_o(valid), .ready_i(ready),
    .startofpacket_o(sop), .endofpacket_o(eop),
    .active_buf_o(active_buf), .frame_done_o(frame_done)
  );

  logic [CB-1:0] mem [2*N];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [CB-1:0] pix;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t          q[$];
  int            n_checks, n_err;
  int            mode;          // 0 idle, 1 streaming, 2 finishing
  int            exp_idx, frame_pix, xfers, rd_cnt;
  logic          exp_buf, exp_active, stall_q;
  logic [CB+2:0] prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   m0;
    logic pop_now;
    m0      = mode;
    pop_now = valid && ready;
    if (stall_q) check("stall_hold", 32'({valid, sop, eop, pixel}), 32'(prev_out));
    stall_q  = valid && !ready;
    prev_out = {valid, sop, eop, pixel};
    if (m0 == 0) check("idle_quiet", 32'({rd_en, valid}), 0);
    check("active_buf", 32'(active_buf), 32'(exp_active));
    if (pop_now) begin
      check("xfer_has_expect", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pixel", 32'(pixel), 32'(e.pix));
        check("sop", 32'(sop), 32'(e.sop));
        check("eop", 32'(eop), 32'(e.eop));
        check("frame_done", 32'(frame_done), 32'(e.eop));
        xfers++;
        frame_pix = e.sop ? 1 : frame_pix + 1;
        if (e.eop) begin
          check("frame_len", frame_pix, N);
          if (m0 == 2) mode = 0;
          else exp_active = exp_buf;
        end
      end
    end else begin
      check("frame_done_quiet", 32'(frame_done), 0);
    end
    if (rd_en) begin
      rd_cnt++;
      check("rd_addr", 32'(rd_addr), 32'({exp_buf, exp_idx[AW-1:0]}));
      q.push_back('{pix: mem[{exp_buf, exp_idx[AW-1:0]}], sop: (exp_idx == 0), eop: (exp_idx == N-1)});
      check("read_lead", 32'(q.size() <= 2), 1);
      if (exp_idx == N-1) begin
        exp_idx = 0;
        exp_buf = buf_select;
        if (!enable) mode = 2;
      end else begin
        exp_idx++;
      end
    end
    if (m0 == 0 && enable) begin
      mode       = 1;
      exp_idx    = 0;
      exp_buf    = buf_select;
      exp_active = buf_select;
    end
  endtask

  task automatic cycle();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_sop", 32'(sop), 0);
    check("rst_eop", 32'(eop), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_active_buf", 32'(active_buf), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    q.delete();
    mode = 0; exp_idx = 0; exp_buf = 1'b0; exp_active = 1'b0; stall_q = 1'b0; frame_pix = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_pix(input int target);
    int n = 0;
    while (frame_pix != target && n < 4*N) begin
      cycle();
      n++;
    end
    check("wait_pix_timeout", 32'(frame_pix == target), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mode != 0 && n < 4*N) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(mode == 0), 1);
  endtask

  initial begin
    int x0, r0, n;
    for (int i = 0; i < 2*N; i++) mem[i] = CB'(i * 97 + 11);
    n_checks = 0; n_err = 0; xfers = 0; rd_cnt = 0; frame_pix = 0;
    reset_n = 1'b1; enable = 1'b0; buf_select = 1'b0; ready = 1'b1;
    #2;
    do_reset();

    // latency, continuous streaming across frame boundaries
    cycle();
    enable = 1'b1;
    cycle();
    check("lat_rd_en", 32'(rd_en), 1);
    check("lat_addr0", 32'(rd_addr), 0);
    check("lat_valid0", 32'(valid), 0);
    cycle();
    check("lat_addr1", 32'(rd_addr), 1);
    check("lat_valid1", 32'(valid), 0);
    cycle();
    check("lat_valid2", 32'(valid), 1);
    check("lat_sop", 32'(sop), 1);
    check("lat_pix0", 32'(pixel), 32'(mem[0]));
    x0 = xfers;
    repeat (2*N) cycle();
    check("throughput", xfers - x0, 2*N);

    // random backpressure, roughly 30% low
    repeat (3*N) begin
      ready = ($urandom_range(0, 9) >= 3);
      cycle();
    end
    ready = 1'b1;

    // buffer swap mid-frame takes effect at the next frame
    wait_pix(5);
    buf_select = 1'b1;
    repeat (2*N + 4) cycle();
    check("swap_active", 32'(active_buf), 1);

    // enable drops mid-frame: full frame still delivered, then idle and restart
    wait_pix(5);
    enable = 1'b0;
    buf_select = 1'b0;
    wait_idle();
    repeat (3) cycle();
    check("stop_rd_en", 32'(rd_en), 0);
    check("stop_valid", 32'(valid), 0);
    enable = 1'b1;
    cycle();
    check("restart_rd_en", 32'(rd_en), 1);
    check("restart_addr", 32'(rd_addr), 0);

    // reset during a stall abandons the frame
    wait_pix(5);
    ready = 1'b0;
    repeat (4) cycle();
    do_reset();
    ready = 1'b1;
    n = 0;
    while (!valid && n < 10) begin
      cycle();
      n++;
    end
    check("rst_restart_sop", 32'(sop), 1);
    check("rst_restart_pix", 32'(pixel), 32'(mem[0]));
    repeat (N) cycle();

    // sink stalled from the start: only two reads, then pixel 0 first
    enable = 1'b0;
    ready = 1'b0;
    do_reset();
    enable = 1'b1;
    r0 = rd_cnt;
    repeat (10) cycle();
    check("stall_reads", rd_cnt - r0, 2);
    check("stall_full_valid", 32'(valid), 1);
    check("stall_first_sop", 32'(sop), 1);
    check("stall_first_pix", 32'(pixel), 32'(mem[0]));
    ready = 1'b1;
    repeat (2*N) cycle();
    enable = 1'b0;
    wait_idle();
    cycle();
    check("end_rd_en", 32'(rd_en), 0);
    check("end_queue_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
